oport_wrr_arbiter: RTL and testbench
====================================

# oport_wrr_arbiter

Packet-level weighted round-robin arbiter for one router output port. It shares that port's crossbar output among the N input ports that request it. Once a multi-flit packet wins, the grant is held (wormhole lock) until the packet's tail flit passes. The round-robin pointer advances only after the current holder has sent `weight` packets. One instance sits per output port, between the input-port request logic and the crossbar select.

## Interface
- `N`, default 4: number of requesting input ports (P-1 for a 5-port router).
- `WEIGHTw`, default 4: width of each per-requester weight and of the packet counter.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, N: requester i has a flit ready for this output port.
- `tail`, input, N: the head-of-queue flit of requester i is a tail flit. Single-flit packets assert `req` and `tail` together.
- `weight_all`, input, N*WEIGHTw: weight of requester i in bits [i*WEIGHTw +: WEIGHTw]. A weight of 0 is treated as 1.
- `oport_ready`, input, 1: output has credit/space and can accept a flit this cycle.
- `grant`, output, N: one-hot, or all zero. Combinational.
- `grant_valid`, output, 1: OR of `grant`.
- `locked`, output, 1: registered; a multi-flit packet is in progress.
- `weight_consumed`, output, N: one-cycle combinational pulse on bit g when the pointer leaves requester g.

## Operation
- State registers:
  - `ptr` (clog2 N bits): round-robin priority holder.
  - `cnt` (WEIGHTw bits): packets served for `ptr`.
  - `locked` (1 bit).
  - `owner` (clog2 N bits).
- Grant, evaluated every cycle:
  - If `reset` or `!oport_ready`: `grant` = 0.
  - Else if `locked`: `grant[owner]` = `req[owner]`; all other bits are 0.
  - Else: `grant` = the first set bit of `req`, searching circularly from `ptr` upward.
- Update, on each cycle with a grant to g:
  - `tail[g]` = 0 and not `locked`: set `locked` = 1, `owner` = g. Pointer and counter are unchanged.
  - `tail[g]` = 1 (packet completes): clear `locked`. Then, with w = max(weight_g, 1):
    - If g == `ptr` and `cnt`+1 < w: `cnt` += 1.
    - Else if g != `ptr` and w > 1: `ptr` = g, `cnt` = 1.
    - Otherwise: `ptr` = (g+1) mod N, `cnt` = 0, and `weight_consumed[g]` pulses.
  - Locked and `tail[g]` = 0 (body flit): no state change.
- Weight is sampled only at the cycle a packet completes. Changing the weight mid-packet affects only that completion decision.
- Boundary behaviour:
  - Owner deasserts `req` while locked: bubble cycle with `grant` = 0. The lock is held and other requesters stay blocked.
  - `oport_ready` low: no grant and no state change, locked or not.
  - `cnt` never reaches w because it resets at w-1 (+1); no overflow occurs.
  - `ptr` wraps from N-1 to 0.
  - Reset mid-packet clears the lock immediately; the next grant is a fresh arbitration from `ptr` = 0.

## Timing
- Grant latency: 0 cycles. `grant` is valid in the same cycle as `req`/`oport_ready`. The crossbar registers it downstream.
- State updates happen at the rising edge following the granted cycle.
- A single-flit packet is granted and completed in one cycle. Back-to-back grants to different requesters are possible on consecutive cycles.
- Reset values: `ptr` = 0, `cnt` = 0, `locked` = 0, `owner` = 0, `grant` = 0, `grant_valid` = 0, `weight_consumed` = 0.
- No combinational path from `grant` back to `req` or `tail` is assumed. Those inputs must not depend on `grant` in the same cycle.

## Structure
- Shared package/header: the `clog2` function and the `WEIGHTw` default constant. These are reused by the per-port weight registers in the input ports.
- One natural sub-module, `rr_first_one_onehot`: a combinational circular priority search. Inputs are `req[N]` and `ptr`; output is a one-hot `grant[N]`. Implement it as a doubled-vector, mask-then-find-first.
- The top level holds the state registers, the lock/owner logic and the weight-completion logic.

## Test plan
- Reset, then `req`=4'b1111, `tail`=4'b1111, all weights 1, `oport_ready`=1 for 8 cycles → grant sequence 0,1,2,3,0,1,2,3, and `weight_consumed` pulses each cycle.
- Weights {3,1,1,1}, all requesting single-flit packets → grant sequence 0,0,0,1,2,3,0,0,0; `cnt` on `ptr`=0 goes 1,2, then `ptr` moves to 1.
- Requester 2 sends a 4-flit packet (`tail` only on the 4th granted flit) while requesters 0, 1 and 3 request continuously → `locked`=1 for cycles 2–4 with `grant`=4'b0100 throughout; after the tail, arbitration resumes at 3.
- While locked on owner 1, `req[1]` drops for 2 cycles → `grant`=0 for those 2 cycles, `locked` stays 1, requester 0 is never granted; when `req[1]` returns, the packet resumes.
- `oport_ready`=0 for 3 cycles during a locked packet → no grant and `ptr`/`cnt`/`owner` unchanged; traffic resumes identically when `oport_ready`=1.
- Assert `reset` mid-packet (locked on owner 3, `ptr`=3) → `locked`=0 and `grant`=0 asynchronously; after release, `req`=4'b1010 yields a grant to 1.

Source files
------------

// File: rtl/oport_wrr_arbiter_pkg.sv
// rtl/oport_wrr_arbiter_pkg.sv - shared constants and helpers for the output-port WRR arbiter
package oport_wrr_arbiter_pkg;

  // Default width of per-requester weights and the packet counter
  localparam int WEIGHTW_DEFAULT = 4;

  // Ceiling log2, never below 1 so a single requester still gets a 1-bit index
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/oport_wrr_arbiter_rr_first_one_onehot.sv
// rtl/oport_wrr_arbiter_rr_first_one_onehot.sv - circular first-one search from a priority pointer
module rr_first_one_onehot #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Double the request vector, drop bits below ptr, isolate the lowest survivor, fold halves
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    first  = masked & ~(masked - {{(2*N-1){1'b0}}, 1'b1});
    grant  = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/oport_wrr_arbiter.sv
// rtl/oport_wrr_arbiter.sv - packet-level weighted round-robin arbiter with wormhole lock
module oport_wrr_arbiter
  import oport_wrr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int WEIGHTw = WEIGHTW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         tail,
  input  logic [N*WEIGHTw-1:0] weight_all,
  input  logic                 oport_ready,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic                 locked,
  output logic [N-1:0]         weight_consumed
);

  localparam int PW = clog2(N);
  localparam logic [PW-1:0]      LAST  = PW'(N - 1);
  localparam logic [WEIGHTw-1:0] W_ONE = WEIGHTw'(1);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [WEIGHTw-1:0] cnt;

  logic [N-1:0]       rr_grant;
  logic [PW-1:0]      g_idx;
  logic [WEIGHTw-1:0] g_weight;
  logic [WEIGHTw-1:0] w_eff;
  logic [WEIGHTw:0]   cnt_next;
  logic [PW-1:0]      ptr_next;
  logic               complete;
  logic               keep_ptr;
  logic               jump;
  logic               advance;

  rr_first_one_onehot #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // Grant: suppressed in reset or without credit, pinned to the owner while a packet is open
  always_comb begin
    grant = '0;
    if (!reset && oport_ready) begin
      if (locked) grant[owner] = req[owner];
      else        grant = rr_grant;
    end
  end

  assign grant_valid = |grant;

  // Encode the granted requester and pick up its weight
  always_comb begin
    g_idx    = '0;
    g_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        g_idx    = PW'(i);
        g_weight = weight_all[i*WEIGHTw +: WEIGHTw];
      end
    end
  end

  // Completion decision: stay on ptr, jump ptr to a heavier winner, or move past the winner
  always_comb begin
    w_eff    = (g_weight == '0) ? W_ONE : g_weight;
    cnt_next = {1'b0, cnt} + {{WEIGHTw{1'b0}}, 1'b1};
    ptr_next = (g_idx == LAST) ? '0 : g_idx + PW'(1);
    complete = grant_valid && tail[g_idx];
    keep_ptr = (g_idx == ptr) && (cnt_next < {1'b0, w_eff});
    jump     = (g_idx != ptr) && (w_eff > W_ONE);
    advance  = complete && !keep_ptr && !jump;
  end

  // Pulse the requester the pointer is leaving
  always_comb begin
    weight_consumed = '0;
    if (advance) weight_consumed[g_idx] = 1'b1;
  end

  // Arbitration state: pointer, served-packet counter, wormhole lock and owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      cnt    <= '0;
      locked <= 1'b0;
      owner  <= '0;
    end else if (grant_valid) begin
      if (tail[g_idx]) begin
        locked <= 1'b0;
        if (keep_ptr) begin
          cnt <= cnt_next[WEIGHTw-1:0];
        end else if (jump) begin
          ptr <= g_idx;
          cnt <= W_ONE;
        end else begin
          ptr <= ptr_next;
          cnt <= '0;
        end
      end else if (!locked) begin
        locked <= 1'b1;
        owner  <= g_idx;
      end
    end
  end

endmodule

// File: tb/tb_oport_wrr_arbiter.sv
// tb/tb_oport_wrr_arbiter.sv - self-checking bench for oport_wrr_arbiter
module tb_oport_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  tail;
  logic [N*WW-1:0] weight_all;
  logic          oport_ready;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic          locked;
  logic [N-1:0]  weight_consumed;

  int checks = 0;
  int errors = 0;

  logic [N*WW-1:0] next_w;

  oport_wrr_arbiter #(.N(N), .WEIGHTw(WW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .tail            (tail),
    .weight_all      (weight_all),
    .oport_ready     (oport_ready),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .locked          (locked),
    .weight_consumed (weight_consumed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scalar priority holder, served count, lock flag and owner
  int m_ptr = 0;
  int m_cnt = 0;
  int m_owner = 0;
  bit m_locked = 0;

  function automatic int eff_weight(input int i);
    int w;
    w = int'(weight_all[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int pick();
    if (reset || !oport_ready) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit leaves(input int g);
    int w;
    w = eff_weight(g);
    if (!tail[g]) return 0;
    if (g == m_ptr && m_cnt + 1 < w) return 0;
    if (g != m_ptr && w > 1) return 0;
    return 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    int w;
    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_owner = 0; m_locked = 0;
    end else begin
      g = pick();
      if (g >= 0) begin
        if (tail[g]) begin
          w = eff_weight(g);
          m_locked = 0;
          if (g == m_ptr && m_cnt + 1 < w) m_cnt = m_cnt + 1;
          else if (g != m_ptr && w > 1) begin m_ptr = g; m_cnt = 1; end
          else begin m_ptr = (g + 1) % N; m_cnt = 0; end
        end else if (!m_locked) begin
          m_locked = 1;
          m_owner  = g;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    logic [N-1:0] ewc;
    g = pick();
    eg = '0;
    ewc = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      if (leaves(g)) ewc[g] = 1'b1;
    end
    chk("model grant", grant, eg);
    chk("model grant_valid", {3'b000, grant_valid}, {3'b000, |eg});
    chk("model locked", {3'b000, locked}, {3'b000, m_locked});
    chk("model weight_consumed", weight_consumed, ewc);
  end

  // One cycle of directed stimulus with hand-computed expectations
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic rdy,
                      input logic [N-1:0] eg, input logic el, input logic [N-1:0] ewc,
                      input string nm);
    @(posedge clk); #1;
    reset = 1'b0;
    req = r; tail = t; oport_ready = rdy; weight_all = next_w;
    @(negedge clk); #1;
    chk({nm, " grant"}, grant, eg);
    chk({nm, " locked"}, {3'b000, locked}, {3'b000, el});
    chk({nm, " weight_consumed"}, weight_consumed, ewc);
  endtask

  localparam logic [N*WW-1:0] W_ALL1 = {4'd1, 4'd1, 4'd1, 4'd1};

  logic [N-1:0] seq1 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [N-1:0] seq2 [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
  logic [N-1:0] wc2  [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

  initial begin
    reset = 1'b1; req = 4'b1111; tail = 4'b1111; oport_ready = 1'b1;
    weight_all = W_ALL1; next_w = W_ALL1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset grant", grant, 4'b0000);
    chk("reset grant_valid", {3'b000, grant_valid}, 4'b0000);
    chk("reset locked", {3'b000, locked}, 4'b0000);
    chk("reset weight_consumed", weight_consumed, 4'b0000);

    // Equal weights: plain rotation, every grant consumes
    for (int i = 0; i < 8; i++) step(4'b1111, 4'b1111, 1'b1, seq1[i], 1'b0, seq1[i], "rr_w1");

    // Requester 0 weighted 3
    next_w = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < 9; i++) step(4'b1111, 4'b1111, 1'b1, seq2[i], 1'b0, wc2[i], "wrr_w3");

    // Fresh start, then a 4-flit packet from requester 2
    next_w = W_ALL1;
    @(posedge clk); #1 reset = 1'b1;
    step(4'b1111, 4'b1011, 1'b1, 4'b0001, 1'b0, 4'b0001, "pkt4 c0");
    step(4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b0, 4'b0010, "pkt4 c1");
    step(4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b0, 4'b0000, "pkt4 head");
    step(4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b1, 4'b0000, "pkt4 body1");
    step(4'b1111, 4'b1011, 1'b1, 4'b0100, 1'b1, 4'b0000, "pkt4 body2");
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, "pkt4 tail");
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 4'b1000, "pkt4 resume");

    // Owner 1 drops req while locked: bubbles, requester 0 blocked
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, "bubble head");
    step(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, "bubble 1");
    step(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, "bubble 2");
    step(4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, "bubble tail");
    step(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0001, "bubble after");

    // No credit during a locked packet
    step(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, "stall head");
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, "stall");
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, "stall tail");
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0100, "stall after");

    // Non-pointer winner with weight 2 takes the pointer; weight 0 acts as 1
    next_w = {4'd0, 4'd1, 4'd2, 4'd1};
    step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 4'b0000, "jump");
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 4'b0010, "jump second");
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0100, "jump next");
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 4'b1000, "weight0 wrap");

    // Reset mid-packet with owner 3 and ptr 3
    next_w = W_ALL1;
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b0001, "pre c0");
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 4'b0010, "pre c1");
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0100, "pre c2");
    step(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'b0000, "own3 head");
    step(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0000, "own3 body");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async reset grant", grant, 4'b0000);
    chk("async reset locked", {3'b000, locked}, 4'b0000);
    step(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b0, 4'b0010, "post reset");

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
